// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and flag bit positions for the
// sequential ALU and its multiplier.
`timescale 1ns/1ps
package alu_pkg;

    localparam logic [2:0] ALU_OR   = 3'b000;
    localparam logic [2:0] ALU_NAND = 3'b001;
    localparam logic [2:0] ALU_NOR  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_MUL  = 3'b110;
    localparam logic [2:0] ALU_ILL  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;
    localparam int FLAG_W = 4;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, then a one-cycle
// done pulse while the full 2*WIDTH-bit product sits in the accumulator.
`timescale 1ns/1ps
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic [2*WIDTH-1:0] mcand_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               active_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
            active_reg <= 1'b0;
        end else if (start) begin
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            acc_reg    <= '0;
            count_reg  <= CNT_W'(WIDTH);
            active_reg <= 1'b1;
        end else if (active_reg) begin
            if (count_reg != '0) begin
                if (mplier_reg[0]) begin
                    acc_reg <= acc_reg + mcand_reg;
                end
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                count_reg  <= count_reg - CNT_W'(1);
            end else begin
                active_reg <= 1'b0;
            end
        end
    end

    // The extra cycle at count==0 gives the WIDTH+1 cycle accept-to-valid latency.
    assign done    = active_reg && (count_reg == '0);
    assign product = acc_reg;

endmodule

// File: rtl/alu_seq.sv
// Clocked ALU with operand/result handshakes, status flags and a sequential
// multiply; drives the shared bus only while a result is valid.
`timescale 1ns/1ps
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_sel,
    input  logic [2:0]       alu_order,
    input  logic [WIDTH-1:0] reg_1,
    input  logic [WIDTH-1:0] reg_2,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_n,
    output logic             err,
    output logic             busy
);

    localparam int MSB = WIDTH - 1;

    state_t              state_reg, state_next;
    logic [WIDTH-1:0]    result_reg, result_next;
    logic [FLAG_W-1:0]   flags_reg, flags_next;
    logic                err_reg, err_next;
    logic                accept, start_mul, mul_done, load;
    logic [2*WIDTH-1:0]  product;
    logic [WIDTH:0]      add_full, sub_full;

    assign in_ready  = (state_reg == IDLE) & alu_sel;
    assign accept    = in_valid & in_ready;
    assign start_mul = accept & (alu_order == ALU_MUL);
    assign load      = (accept & ~start_mul) | ((state_reg == MUL) & mul_done);

    alu_mul_seq #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (start_mul),
        .a       (reg_1),
        .b       (reg_2),
        .done    (mul_done),
        .product (product)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)    state_next = start_mul ? MUL : DONE;
            MUL:     if (mul_done)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    assign add_full = {1'b0, reg_1} + {1'b0, reg_2};
    assign sub_full = {1'b0, reg_1} - {1'b0, reg_2};

    // X or 111 opcodes fall through to the default arm and report err.
    always_comb begin
        result_next = '0;
        flags_next  = '0;
        err_next    = 1'b0;
        if (state_reg == MUL) begin
            result_next        = product[WIDTH-1:0];
            flags_next[FLAG_C] = |product[2*WIDTH-1:WIDTH];
        end else begin
            case (alu_order)
                ALU_OR:   result_next = reg_1 | reg_2;
                ALU_NAND: result_next = ~(reg_1 & reg_2);
                ALU_NOR:  result_next = ~(reg_1 | reg_2);
                ALU_AND:  result_next = reg_1 & reg_2;
                ALU_ADD: begin
                    result_next        = add_full[WIDTH-1:0];
                    flags_next[FLAG_C] = add_full[WIDTH];
                    flags_next[FLAG_V] = (reg_1[MSB] == reg_2[MSB]) &
                                         (result_next[MSB] != reg_1[MSB]);
                end
                ALU_SUB: begin
                    result_next        = sub_full[WIDTH-1:0];
                    flags_next[FLAG_C] = ~sub_full[WIDTH];
                    flags_next[FLAG_V] = (reg_1[MSB] != reg_2[MSB]) &
                                         (result_next[MSB] != reg_1[MSB]);
                end
                ALU_MUL:  result_next = '0;
                default:  err_next    = 1'b1;
            endcase
        end
        flags_next[FLAG_Z] = (result_next == '0);
        flags_next[FLAG_N] = result_next[MSB];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            flags_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                result_reg <= result_next;
                flags_reg  <= flags_next;
                err_reg    <= err_next;
            end
        end
    end

    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign alu_out   = out_valid ? result_reg : {WIDTH{1'bz}};
    assign flag_z    = flags_reg[FLAG_Z];
    assign flag_c    = flags_reg[FLAG_C];
    assign flag_v    = flags_reg[FLAG_V];
    assign flag_n    = flags_reg[FLAG_N];
    assign err       = err_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: stimulus pushes hand-computed results into a
// scoreboard queue, a monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, alu_sel, in_valid, out_ready;
    logic [2:0]   alu_order;
    logic [W-1:0] reg_1, reg_2;
    wire  [W-1:0] alu_out;
    logic         in_ready, out_valid, flag_z, flag_c, flag_v, flag_n, err, busy;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_sel   (alu_sel),
        .alu_order (alu_order),
        .reg_1     (reg_1),
        .reg_2     (reg_2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_out   (alu_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_n    (flag_n),
        .err       (err),
        .busy      (busy)
    );

    typedef struct packed {
        logic [W-1:0] r;
        logic z, c, v, n, e;
    } exp_t;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b;
        logic [W-1:0] r;
        logic z, c, v, n, e;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Hand-computed single-cycle vectors: op, A, B, result, Z, C, V, N, err.
    vec_t vecs[9] = '{
        '{ALU_ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
        '{ALU_ADD,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
        '{ALU_SUB,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
        '{ALU_SUB,  8'h01, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
        '{ALU_SUB,  8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
        '{ALU_OR,   8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
        '{ALU_NOR,  8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
        '{ALU_AND,  8'hFF, 8'h81, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
        '{ALU_ILL,  8'h55, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}
    };

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic push(input logic [W-1:0] r, input logic z, c, v, n, e);
        exp_t x;
        x = {r, z, c, v, n, e};
        sb.push_back(x);
    endtask

    // Presents one operation and returns just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        alu_order = op;
        reg_1     = a;
        reg_2     = b;
        in_valid  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid  = 1'b0;
                reg_1     = ~a;
                reg_2     = ~b;
                alu_order = ALU_ILL;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no accept in 50 cycles, expected accept");
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) return;
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout: got busy=%0b pending=%0d, expected idle", busy, sb.size());
    endtask

    task automatic mul_test(input logic [W-1:0] a, b, r, input logic c, n, z);
        int  cyc;
        bit  held;
        push(r, z, c, 1'b0, n, 1'b0);
        send(ALU_MUL, a, b);
        cyc  = 0;
        held = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) break;
            if (in_ready || !busy) held = 1'b0;
            cyc++;
        end
        chk("mul_latency", cyc, W + 1);
        chk("mul_busy_no_ready", {31'd0, held}, 32'd1);
        wait_idle();
    endtask

    // Scoreboard monitor: one compare per result handshake.
    initial begin
        exp_t e, got;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got alu_out=%0h, expected no result", alu_out);
                end else begin
                    e   = sb.pop_front();
                    got = {alu_out, flag_z, flag_c, flag_v, flag_n, err};
                    if (got !== e) begin
                        errors++;
                        $display("FAIL result: got out=%0h zcvn=%0b%0b%0b%0b err=%0b, expected out=%0h zcvn=%0b%0b%0b%0b err=%0b",
                                 got.r, got.z, got.c, got.v, got.n, got.e,
                                 e.r, e.z, e.c, e.v, e.n, e.e);
                    end else begin
                        $display("txn ok: out=%0h zcvn=%0b%0b%0b%0b err=%0b",
                                 got.r, got.z, got.c, got.v, got.n, got.e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        rst       = 1'b1;
        alu_sel   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_order = ALU_OR;
        reg_1     = '0;
        reg_2     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_flags_err", {27'd0, flag_z, flag_c, flag_v, flag_n, err}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        // Single-cycle ops: result visible the cycle after accept.
        foreach (vecs[k]) begin
            push(vecs[k].r, vecs[k].z, vecs[k].c, vecs[k].v, vecs[k].n, vecs[k].e);
            send(vecs[k].op, vecs[k].a, vecs[k].b);
            @(negedge clk);
            chk("single_cycle_latency", {31'd0, out_valid}, 32'd1);
            wait_idle();
        end

        mul_test(8'h10, 8'h11, 8'h10, 1'b1, 1'b0, 1'b0);
        mul_test(8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b1, 1'b0);
        mul_test(8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);

        // Backpressure with a competing request waiting on in_valid.
        out_ready = 1'b0;
        push(8'hCF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        push(8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(ALU_NAND, 8'hF0, 8'h3C);
        @(posedge clk);
        #1;
        alu_order = ALU_OR;
        reg_1     = 8'h01;
        reg_2     = 8'h02;
        in_valid  = 1'b1;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!out_valid || alu_out !== 8'hCF || in_ready) ok = 1'b0;
        end
        chk("backpressure_hold", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("ready_low_in_done", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("idle_after_handshake", {30'd0, in_ready, out_valid}, 32'd2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle();

        // Reset during the 4th multiply cycle discards the operation.
        send(ALU_MUL, 8'h12, 8'h34);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_mul_busy", {30'd0, busy, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ok = 1'b1;
        repeat (W + 4) begin
            @(negedge clk);
            if (out_valid) ok = 1'b0;
        end
        chk("rst_no_result", {31'd0, ok}, 32'd1);
        push(8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(ALU_ADD, 8'h02, 8'h03);
        wait_idle();

        // alu_sel low blocks acceptance.
        @(posedge clk);
        #1;
        alu_sel   = 1'b0;
        alu_order = ALU_ADD;
        reg_1     = 8'h01;
        reg_2     = 8'h01;
        in_valid  = 1'b1;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (in_ready || out_valid || busy) ok = 1'b0;
        end
        chk("sel_low_no_accept", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_sel  = 1'b1;

        // Dropping alu_sel mid-multiply still completes the operation.
        push(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(ALU_MUL, 8'h03, 8'h05);
        alu_sel = 1'b0;
        wait_idle();
        alu_sel = 1'b1;

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, clocked successor to the team's 8-bit combinational ALU. It keeps the same opcode map and adds four things:
- a WIDTH parameter;
- valid/ready handshakes on the operand and result sides;
- status flags (zero, carry, overflow, negative);
- a multi-cycle shift-add multiply.

It sits between the register file read ports and the data bus. It drives the bus only while a result is valid.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH)+1, multiply iteration counter width; derived, not to be overridden.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
alu_sel  in  1  block enable; when 0, no new operation is accepted
alu_order  in  3  opcode, sampled on accept
reg_1  in  WIDTH  operand A, sampled on accept
reg_2  in  WIDTH  operand B, sampled on accept
in_valid  in  1  operand/opcode valid
in_ready  out  1  block can accept; equals (state==IDLE) & alu_sel
alu_out  out  WIDTH  result; high-Z whenever out_valid==0
out_valid  out  1  result and flags valid
out_ready  in  1  consumer takes result
flag_z  out  1  result == 0
flag_c  out  1  carry / no-borrow / multiply high-half nonzero
flag_v  out  1  signed overflow
flag_n  out  1  result MSB
err  out  1  illegal opcode reported with this result
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock domain (clk); rst is asynchronous and active-high.
- Reset values: state=IDLE, out_valid=0, result register=0, all flags=0, err=0, busy=0. alu_out is Z because out_valid=0.
- Accept: an operation is accepted on a clk edge where in_valid & in_ready. Opcode and operands are latched into internal registers on that edge. Later changes on the inputs have no effect.
- Opcodes:
  - 000 OR
  - 001 NAND
  - 010 NOR
  - 011 AND
  - 100 ADD
  - 101 SUB
  - 110 MUL (low WIDTH bits of A*B, unsigned)
  - 111 illegal: result 0, err=1, flag_z=1, other flags 0
- Arithmetic and flag rules:
  - Logic ops: C=0, V=0.
  - ADD: C = carry out of bit WIDTH-1; V = (A[msb]==B[msb]) & (R[msb]!=A[msb]).
  - SUB (A-B): C = 1 when A>=B unsigned (no borrow); V = (A[msb]!=B[msb]) & (R[msb]!=A[msb]).
  - MUL: C = 1 when the upper WIDTH bits of the 2*WIDTH-bit product are nonzero; V=0.
  - All ops: Z and N are computed from the WIDTH-bit result.
- State machine: IDLE, MUL, DONE.
  - IDLE --accept, op!=110--> DONE. Result and flags are registered on the accept edge, so out_valid rises 1 cycle after accept.
  - IDLE --accept, op==110--> MUL, with counter=WIDTH and accumulator=0.
  - MUL: each cycle, if the multiplier LSB is 1, add the shifted multiplicand to the accumulator. Shift the multiplicand left and the multiplier right, and decrement the counter. On the cycle the counter reaches 0, go to DONE. out_valid rises exactly WIDTH+1 cycles after accept.
  - DONE: out_valid=1. alu_out, flags and err are held stable until out_ready=1. Go to IDLE on the edge where out_valid & out_ready.
- No overlap: in_ready is 0 in MUL and in DONE, so the DONE-to-IDLE edge cannot also accept. Maximum throughput is 1 operation per 2 cycles.
- alu_sel deasserted:
  - In IDLE it blocks acceptance.
  - An operation already in MUL or DONE completes normally regardless of alu_sel.
- Reset mid-operation (any state): immediate return to reset values. The in-flight result is discarded and never presented.
- Unknown (X) opcode is treated as 111.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams ALU_OR..ALU_MUL, ALU_ILL;
  - state encoding IDLE/MUL/DONE;
  - flag index constants.
- Sub-module alu_mul_seq holds the shift-add multiplier datapath (counter, accumulator, shift registers, done pulse). The FSM, logic/add/sub datapath, flag generation and bus tri-state stay in alu_seq.

Test Plan:
- WIDTH=8, ADD 0xFF+0x01, out_ready=1 -> next cycle alu_out=0x00, Z=1, C=1, V=0, N=0.
- SUB 0x80-0x01 -> 0x7F, V=1, C=1, N=0. SUB 0x01-0x02 -> 0xFF, C=0, N=1, V=0.
- MUL 0x10*0x11 -> out_valid exactly 9 cycles after accept, alu_out=0x10, C=1. MUL 0x0F*0x0F -> 0xE1, C=0. in_ready=0 and busy=1 throughout.
- Backpressure: NAND 0xF0,0x3C with out_ready=0 for 5 cycles -> alu_out=0xCF held and stable, in_ready=0. A second in_valid is ignored until the cycle after the out_ready handshake.
- Assert rst on the 4th MUL cycle -> out_valid never rises, alu_out=Z, busy=0 immediately. The next ADD 0x02+0x03 returns 0x05.
- Opcode 111 with A=0x55 -> alu_out=0x00, err=1, Z=1. alu_sel=0 with in_valid=1 -> no accept, alu_out stays Z.
